// File: rtl/nn_ctrl_pkg.sv
// Shared types and width helpers for the fully-connected layer sequencer.
// The state encoding is fixed so traces from older builds still decode.
package nn_ctrl_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    WAIT    = 2'd2,
    OUTPUT  = 2'd3
  } ctrl_state_t;

  // Bits needed to index 0..n-1; never below one bit so degenerate counters stay legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_x_width(input int n);
    return cnt_width(n);
  endfunction

  function automatic int addr_w_width(input int m, input int n, input int p);
    return cnt_width((m * n) / p);
  endfunction

endpackage

// File: rtl/nn_layer_ctrl.sv
// Sequencer for one FC+ReLU layer: loads the input vector, walks the weight ROM per
// output group, strobes the accumulators and hands the activations downstream.
module nn_layer_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int M = 16,
  parameter int N = 8,
  parameter int P = 1,
  localparam int XW = addr_x_width(N),
  localparam int AW = addr_w_width(M, N, P)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [XW-1:0] addr_x,
  output logic          wr_en_x,
  output logic [AW-1:0] addr_w,
  output logic          clear_acc,
  output logic          en_acc,
  output logic [P-1:0]  f_sel,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last
);

  localparam int G  = M / P;
  localparam int GW = cnt_width(G);
  localparam int PW = cnt_width(P);

  localparam logic [XW-1:0] J_LAST = XW'(N - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [AW-1:0] N_AW   = AW'(N);

  ctrl_state_t   state_q, state_d;
  logic [XW-1:0] j_q, j_d;
  logic [GW-1:0] g_q, g_d;
  logic [PW-1:0] p_q, p_d;
  logic          clear_acc_q, clear_acc_d;
  logic          en_acc_q, en_acc_d;

  // State is already LOAD while reset is high; s_ready is the only output that needs gating.
  always_comb begin
    s_ready   = (state_q == LOAD) && !reset;
    wr_en_x   = s_valid && s_ready;
    m_valid   = (state_q == OUTPUT);
    m_last    = (state_q == OUTPUT) && (g_q == G_LAST) && (p_q == P_LAST);
    f_sel     = (state_q == OUTPUT) ? (P'(1) << p_q) : '0;
    addr_x    = ((state_q == LOAD) || (state_q == COMPUTE)) ? j_q : '0;
    addr_w    = (state_q == COMPUTE) ? (AW'(g_q) * N_AW + AW'(j_q)) : '0;
    clear_acc = clear_acc_q;
    en_acc    = en_acc_q;
  end

  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    g_d         = g_q;
    p_d         = p_q;
    clear_acc_d = 1'b0;
    en_acc_d    = 1'b0;
    case (state_q)
      LOAD: begin
        if (s_valid && s_ready) begin
          if (j_q == J_LAST) begin
            j_d     = '0;
            g_d     = '0;
            state_d = COMPUTE;
          end else begin
            j_d = j_q + XW'(1);
          end
        end
      end
      COMPUTE: begin
        // Memories read synchronously, so the strobes trail the address by one cycle.
        clear_acc_d = (j_q == '0);
        en_acc_d    = (j_q != '0);
        if (j_q == J_LAST) begin
          j_d     = '0;
          state_d = WAIT;
        end else begin
          j_d = j_q + XW'(1);
        end
      end
      WAIT: begin
        p_d     = '0;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (m_ready) begin
          if (p_q == P_LAST) begin
            p_d = '0;
            if (g_q == G_LAST) begin
              g_d     = '0;
              state_d = LOAD;
            end else begin
              g_d     = g_q + GW'(1);
              state_d = COMPUTE;
            end
          end else begin
            p_d = p_q + PW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= LOAD;
      j_q         <= '0;
      g_q         <= '0;
      p_q         <= '0;
      clear_acc_q <= 1'b0;
      en_acc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      g_q         <= g_d;
      p_q         <= p_d;
      clear_acc_q <= clear_acc_d;
      en_acc_q    <= en_acc_d;
    end
  end

endmodule
